// File: rtl/room_access_controller_if.sv
// Doorway bus between the push-button/sensor side and the room access controller.
// The controller takes the slave modport; the button/sensor side takes the master modport.
interface room_access_controller_if #(
  parameter int CNT_W = 3
);
  logic             req_in;
  logic             req_out;
  logic             pass_in;
  logic             pass_out;
  logic             door_open;
  logic             grant_in;
  logic             grant_out;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             empty;
  logic             timeout;

  modport master (
    output req_in, req_out, pass_in, pass_out,
    input  door_open, grant_in, grant_out, occupancy, full, empty, timeout
  );

  modport slave (
    input  req_in, req_out, pass_in, pass_out,
    output door_open, grant_in, grant_out, occupancy, full, empty, timeout
  );
endinterface

// File: rtl/room_access_controller.sv
// Shares one doorway between entry and exit requesters, round-robin on conflict,
// and keeps the room head count from the per-direction pass-sensor rising edges.
module room_access_controller #(
  parameter int CNT_W    = 3,
  parameter int MAX_OCC  = 7,
  parameter int OPEN_CYC = 8,
  parameter int TMR_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  room_access_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, CLOSE} state_e;
  typedef enum logic {DIR_IN, DIR_OUT} dir_e;

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] OCC_MAX  = CNT_W'(MAX_OCC);

  state_e           state_q, state_d;
  dir_e             last_dir_q, last_dir_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             pass_in_q, pass_out_q;
  logic             door_q, door_d;
  logic             grant_in_q, grant_in_d;
  logic             grant_out_q, grant_out_d;
  logic             timeout_q, timeout_d;

  logic full, empty, rise_in, rise_out, el_in, el_out;

  assign full     = (occ_q == OCC_MAX);
  assign empty    = (occ_q == '0);
  assign rise_in  = bus.pass_in  & ~pass_in_q;
  assign rise_out = bus.pass_out & ~pass_out_q;
  assign el_in    = bus.req_in  & ~full;
  assign el_out   = bus.req_out & ~empty;

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;
    timer_d    = timer_q;
    occ_d      = occ_q;
    timeout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On conflict, serve the direction that did not go last.
        if (el_in && (!el_out || last_dir_q == DIR_OUT)) begin
          state_d    = OPEN_IN;
          timer_d    = '0;
          last_dir_d = DIR_IN;
        end else if (el_out) begin
          state_d    = OPEN_OUT;
          timer_d    = '0;
          last_dir_d = DIR_OUT;
        end
      end
      OPEN_IN: begin
        if (rise_in) begin
          occ_d   = occ_q + CNT_W'(1);
          state_d = CLOSE;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = CLOSE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      OPEN_OUT: begin
        if (rise_out) begin
          occ_d   = occ_q - CNT_W'(1);
          state_d = CLOSE;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = CLOSE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      CLOSE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    grant_in_d  = (state_d == OPEN_IN);
    grant_out_d = (state_d == OPEN_OUT);
    door_d      = grant_in_d | grant_out_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_dir_q  <= DIR_OUT;
      timer_q     <= '0;
      occ_q       <= '0;
      pass_in_q   <= 1'b1;
      pass_out_q  <= 1'b1;
      door_q      <= 1'b0;
      grant_in_q  <= 1'b0;
      grant_out_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      timer_q     <= timer_d;
      occ_q       <= occ_d;
      pass_in_q   <= bus.pass_in;
      pass_out_q  <= bus.pass_out;
      door_q      <= door_d;
      grant_in_q  <= grant_in_d;
      grant_out_q <= grant_out_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.door_open = door_q;
  assign bus.grant_in  = grant_in_q;
  assign bus.grant_out = grant_out_q;
  assign bus.occupancy = occ_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_room_access_controller.sv
// Directed bench for room_access_controller: inputs change and outputs are sampled on the falling edge.
module tb_room_access_controller;
  localparam int CNT_W    = 3;
  localparam int MAX_OCC  = 7;
  localparam int OPEN_CYC = 8;
  localparam int TMR_W    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  room_access_controller_if #(.CNT_W(CNT_W)) bus();

  room_access_controller #(
    .CNT_W(CNT_W), .MAX_OCC(MAX_OCC), .OPEN_CYC(OPEN_CYC), .TMR_W(TMR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit ok;
  bit seen;
  int open_n, to_n;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic pass_level);
    rst          = 1'b1;
    bus.req_in   = 1'b0;
    bus.req_out  = 1'b0;
    bus.pass_in  = pass_level;
    bus.pass_out = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input bit want_out, output bit got);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (want_out ? bus.grant_out : bus.grant_in) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic enter_once();
    bit g;
    bus.req_in = 1'b1;
    tick();
    wait_grant(1'b0, g);
    check("enter_grant", int'(g), 1);
    bus.req_in  = 1'b0;
    bus.pass_in = 1'b1;
    tick();
    bus.pass_in = 1'b0;
    tick();
  endtask

  task automatic exit_once();
    bit g;
    bus.req_out = 1'b1;
    tick();
    wait_grant(1'b1, g);
    check("exit_grant", int'(g), 1);
    bus.req_out  = 1'b0;
    bus.pass_out = 1'b1;
    tick();
    bus.pass_out = 1'b0;
    tick();
  endtask

  // Entry grant with no valid passage; counts open cycles and timeout pulses.
  task automatic measure_open(input bit toggle_out, output int opened, output int touts);
    opened = 0;
    touts  = 0;
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.door_open) opened++;
      if (bus.timeout) touts++;
      if (toggle_out) bus.pass_out = ~bus.pass_out;
      tick();
    end
    bus.pass_out = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: sensor held high through reset, then a single entry
    do_reset(1'b1);
    check("rst_occupancy", int'(bus.occupancy), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_door", int'(bus.door_open), 0);
    check("rst_grant_in", int'(bus.grant_in), 0);
    check("rst_grant_out", int'(bus.grant_out), 0);
    check("rst_timeout", int'(bus.timeout), 0);
    tick(); tick(); tick();
    check("held_sensor_no_count", int'(bus.occupancy), 0);
    bus.req_in = 1'b1;
    check("grant_before_latency", int'(bus.grant_in), 0);
    tick();
    check("grant_latency", int'(bus.grant_in), 1);
    check("door_latency", int'(bus.door_open), 1);
    bus.req_in = 1'b0;
    tick();
    check("held_sensor_in_open", int'(bus.occupancy), 0);
    bus.pass_in = 1'b0;
    tick();
    bus.pass_in = 1'b1;
    tick();
    check("first_entry_occ", int'(bus.occupancy), 1);
    check("first_entry_empty", int'(bus.empty), 0);
    check("first_entry_close", int'(bus.grant_in), 0);
    bus.pass_in = 1'b0;
    tick();

    // 2: fill the room, entry refused, one exit
    do_reset(1'b0);
    repeat (7) enter_once();
    check("fill_occ", int'(bus.occupancy), 7);
    check("fill_full", int'(bus.full), 1);
    bus.req_in = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus.grant_in) seen = 1'b1;
    end
    check("full_blocks_entry", int'(seen), 0);
    bus.req_in = 1'b0;
    exit_once();
    check("exit_from_full_occ", int'(bus.occupancy), 6);
    check("exit_from_full_full", int'(bus.full), 0);

    // 3: round-robin with both requests held at occupancy 3, last direction = exit
    do_reset(1'b0);
    repeat (4) enter_once();
    exit_once();
    check("rr_start_occ", int'(bus.occupancy), 3);
    bus.req_in  = 1'b1;
    bus.req_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (bus.grant_in || bus.grant_out) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check($sformatf("rr_granted_%0d", k), int'(seen), 1);
      check($sformatf("rr_out_%0d", k), int'(bus.grant_out), k % 2);
      check($sformatf("rr_in_%0d", k), int'(bus.grant_in), 1 - (k % 2));
      if (k % 2 == 1) bus.pass_out = 1'b1;
      else bus.pass_in = 1'b1;
      tick();
      check($sformatf("rr_close_gap_%0d", k), int'(bus.door_open), 0);
      bus.pass_in  = 1'b0;
      bus.pass_out = 1'b0;
    end
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;
    tick(); tick(); tick();
    check("rr_end_occ", int'(bus.occupancy), 3);

    // 4: timeout, then passage racing the expiry
    do_reset(1'b0);
    measure_open(1'b0, open_n, to_n);
    check("timeout_open_cycles", open_n, OPEN_CYC);
    check("timeout_pulses", to_n, 1);
    check("timeout_occ", int'(bus.occupancy), 0);
    bus.req_in = 1'b1;
    tick();
    bus.req_in = 1'b0;
    seen = 1'b0;
    repeat (7) begin
      if (bus.timeout) seen = 1'b1;
      tick();
    end
    check("race_door_8th", int'(bus.door_open), 1);
    bus.pass_in = 1'b1;
    tick();
    check("race_occ", int'(bus.occupancy), 1);
    check("race_timeout", int'(bus.timeout | seen), 0);
    bus.pass_in = 1'b0;
    tick(); tick();

    // 5: opposite sensor ignored; exit refused when empty
    measure_open(1'b1, open_n, to_n);
    check("opp_open_cycles", open_n, OPEN_CYC);
    check("opp_timeout_pulses", to_n, 1);
    check("opp_occ", int'(bus.occupancy), 1);
    do_reset(1'b0);
    bus.req_out = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (bus.grant_out) seen = 1'b1;
    end
    check("empty_blocks_exit", int'(seen), 0);
    bus.req_out = 1'b0;

    // 6: reset mid-grant coinciding with a passage
    do_reset(1'b0);
    enter_once();
    enter_once();
    check("pre_reset_occ", int'(bus.occupancy), 2);
    bus.req_out = 1'b1;
    tick();
    check("mid_rst_grant", int'(bus.grant_out), 1);
    bus.req_out = 1'b0;
    tick(); tick();
    rst          = 1'b1;
    bus.pass_out = 1'b1;
    tick();
    check("mid_rst_occ", int'(bus.occupancy), 0);
    check("mid_rst_empty", int'(bus.empty), 1);
    check("mid_rst_grant_out", int'(bus.grant_out), 0);
    check("mid_rst_grant_in", int'(bus.grant_in), 0);
    check("mid_rst_door", int'(bus.door_open), 0);
    check("mid_rst_timeout", int'(bus.timeout), 0);
    rst = 1'b0;
    tick(); tick();
    check("post_rst_idle_door", int'(bus.door_open), 0);
    check("post_rst_occ", int'(bus.occupancy), 0);
    bus.pass_out = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/room_access_controller.md
Name: room_access_controller

Overview:
- Controller that shares the single doorway between entry and exit requesters and keeps the room occupancy count.
- Grants the door to one direction at a time and confirms each passage from the per-direction pass sensor.
- Updates occupancy on a confirmed passage and refuses entry when full or exit when empty.
- Sits between the door push-buttons/sensors and the occupancy display/lock logic.

Parameters:
- CNT_W, 3: width of the occupancy count.
- MAX_OCC, 7: room capacity; must be ≤ 2^CNT_W − 1.
- OPEN_CYC, 8: cycles the door stays open waiting for a passage before timing out; must be ≥ 2.
- TMR_W, 4: timer width; must satisfy 2^TMR_W ≥ OPEN_CYC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_in  in  1  level request to enter.
- req_out  in  1  level request to exit.
- pass_in  in  1  entry-side pass sensor; a passage is its 0→1 edge.
- pass_out  in  1  exit-side pass sensor; a passage is its 0→1 edge.
- door_open  out  1  door unlock, registered.
- grant_in  out  1  entry direction granted, registered.
- grant_out  out  1  exit direction granted, registered.
- occupancy  out  CNT_W  current head count, registered.
- full  out  1  occupancy == MAX_OCC.
- empty  out  1  occupancy == 0.
- timeout  out  1  one-cycle pulse when a grant expires with no passage.

Behaviour:
- **Reset (synchronous):** state=IDLE, occupancy=0, timer=0, last_dir=EXIT. door_open, grant_in, grant_out and timeout are 0. full=0, empty=1. pass_in_d and pass_out_d = 1, so a sensor held high through reset is not seen as an edge. Reset overrides everything, including mid-grant; any pending count change is dropped.
- **Edge detect:** pass_x_d <= pass_x every cycle outside reset. rise_x = pass_x & ~pass_x_d.
- **Eligibility:** el_in = req_in & ~full; el_out = req_out & ~empty.
- **States:** IDLE, OPEN_IN, OPEN_OUT, CLOSE.
- **IDLE:**
  - Only el_in: go to OPEN_IN.
  - Only el_out: go to OPEN_OUT.
  - Both eligible: round-robin, serving the direction opposite to last_dir. The first conflict after reset therefore goes to entry.
  - Neither eligible: stay in IDLE.
  - On any grant: timer<=0 and last_dir<=granted direction.
- **Grant latency:** grant_x and door_open go high the cycle after the request is sampled in IDLE.
- **OPEN_x:**
  - grant_x=1, door_open=1, other grant=0.
  - Each cycle without rise_x, timer increments.
  - rise_x: occupancy +1 (OPEN_IN) or −1 (OPEN_OUT), registered next edge; go to CLOSE.
  - No rise_x and timer == OPEN_CYC−1: timeout pulse next cycle; go to CLOSE; occupancy unchanged. The door is therefore open exactly OPEN_CYC cycles on timeout.
  - rise_x in the same cycle the timer expires: the passage wins, the count changes and no timeout is raised.
  - A rising edge on the opposite sensor is ignored and not counted.
  - A second rise_x in the same grant cannot occur, because the block leaves OPEN on the first.
  - A request dropping mid-grant has no effect; the grant runs to a passage or timeout.
- **CLOSE:** all grants and door_open are 0 for exactly one cycle, requests are ignored, then IDLE. This guarantees at least one closed cycle between consecutive grants.
- **Occupancy range:** occupancy never exceeds MAX_OCC or underflows 0, since grants are gated by full/empty. No wrap-around logic is needed, but the arithmetic is CNT_W bits.
- **Flags:** full and empty are decoded from the occupancy register, so they update in the same cycle as occupancy.
- **Timeout pulse:** timeout is high only in the first CLOSE cycle after an expiry.

Test Plan:
1. Reset with pass_in held 1, release, keep pass_in 1 → no count. Pulse req_in, then drop and raise pass_in → grant_in high 1 cycle after request, occupancy 0→1, empty→0.
2. Seven entries back-to-back → occupancy=7 and full=1. Then req_in held for 20 cycles → grant_in stays 0. Then req_out plus a pass_out edge → occupancy=6 and full=0.
3. req_in and req_out both high continuously from reset at occupancy=3, pass sensor toggled each grant → grants alternate IN, OUT, IN, OUT, with a 1-cycle CLOSE gap between them.
4. req_in, no pass → door_open high exactly 8 cycles, timeout pulses once, occupancy unchanged. Repeat with the pass_in edge on the 8th open cycle → count increments and timeout stays 0.
5. In OPEN_IN, toggle pass_out only → no count change and timeout after 8 cycles. At occupancy=0, req_out → never granted.
6. Assert rst on the 3rd cycle of OPEN_OUT with a pass_out edge in the same cycle → next cycle occupancy=0, state IDLE, all grants 0, timeout 0.
